// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline-register view used by the ID-stage hazard/stall controller.
// master = pipeline datapath side, slave = hazard_stall_unit.
interface hazard_stall_unit_if #(
  parameter int REG_W  = 5,
  parameter int STAT_W = 32
);
  logic [REG_W-1:0]  IFID_rs;
  logic [REG_W-1:0]  IFID_rt;
  logic              IFID_use_rs;
  logic              IFID_use_rt;
  logic [2:0]        IFID_pcsrc;
  logic              branch_taken;
  logic [REG_W-1:0]  IDEX_rd;
  logic              IDEX_regwr;
  logic              IDEX_memrd;
  logic [REG_W-1:0]  EXMEM_rd;
  logic              EXMEM_memrd;
  logic              EXMEM_regwr;
  logic              PC_write;
  logic              IFID_write;
  logic              IFID_flush;
  logic              IDEX_flush;
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] flush_count;
  modport master (
    output IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt, IFID_pcsrc, branch_taken,
           IDEX_rd, IDEX_regwr, IDEX_memrd, EXMEM_rd, EXMEM_memrd, EXMEM_regwr,
    input  PC_write, IFID_write, IFID_flush, IDEX_flush, stall_cycles, flush_count
  );
  modport slave (
    input  IFID_rs, IFID_rt, IFID_use_rs, IFID_use_rt, IFID_pcsrc, branch_taken,
           IDEX_rd, IDEX_regwr, IDEX_memrd, EXMEM_rd, EXMEM_memrd, EXMEM_regwr,
    output PC_write, IFID_write, IFID_flush, IDEX_flush, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage load-use / branch-operand stall and IF/ID flush controller.
// Define HAZARD_STATS_EN to enable the stall_cycles / flush_count statistics counters.
module hazard_stall_unit #(
  parameter int REG_W  = 5,
  parameter int STAT_W = 32
) (
  input logic              clk,
  input logic              reset,
  hazard_stall_unit_if.slave hs
);
  typedef enum logic {RUN, HOLD} state_t;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       dep_ex, dep_mem, br, stall, redirect;
  logic [1:0] n;
  always_comb begin
    dep_ex  = (hs.IDEX_rd != '0) &&
              ((hs.IFID_use_rs && hs.IFID_rs == hs.IDEX_rd) || (hs.IFID_use_rt && hs.IFID_rt == hs.IDEX_rd));
    dep_mem = (hs.EXMEM_rd != '0) &&
              ((hs.IFID_use_rs && hs.IFID_rs == hs.EXMEM_rd) || (hs.IFID_use_rt && hs.IFID_rt == hs.EXMEM_rd));
    br      = hs.IFID_pcsrc == 3'b001 || hs.IFID_pcsrc == 3'b011;
    n       = (br && hs.IDEX_memrd && hs.IDEX_regwr && dep_ex) ? 2'd2 :
              ((!br && hs.IDEX_memrd && hs.IDEX_regwr && dep_ex) ||
               (br && !hs.IDEX_memrd && hs.IDEX_regwr && dep_ex) ||
               (br && hs.EXMEM_memrd && hs.EXMEM_regwr && dep_mem)) ? 2'd1 : 2'd0;
    // HOLD ignores detection so a dependent chain restarts counting only back in RUN
    stall   = (state_q == HOLD) || (n != 2'd0);
    redirect = hs.IFID_pcsrc == 3'b010 || hs.IFID_pcsrc == 3'b011 ||
               (hs.IFID_pcsrc == 3'b001 && hs.branch_taken);
    state_d = (state_q == HOLD) ? ((cnt_q == 2'd1) ? RUN : HOLD) : ((n == 2'd2) ? HOLD : RUN);
    cnt_d   = (state_q == HOLD) ? cnt_q - 2'd1 : ((n != 2'd0) ? n - 2'd1 : 2'd0);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  assign hs.PC_write   = !stall;
  assign hs.IFID_write = !stall;
  assign hs.IDEX_flush = stall;
  assign hs.IFID_flush = !stall && redirect;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
  always_comb begin
    stall_cycles_d = stall_cycles_q + (stall ? STAT_W'(1) : STAT_W'(0));
    flush_count_d  = flush_count_q + (hs.IFID_flush ? STAT_W'(1) : STAT_W'(0));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  assign hs.stall_cycles = stall_cycles_q;
  assign hs.flush_count  = flush_count_q;
`else
  assign hs.stall_cycles = '0;
  assign hs.flush_count  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: table-driven check of stall/flush sequencing plus async reset during HOLD.
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  hazard_stall_unit_if #(.REG_W(5), .STAT_W(32)) hsif ();
  hazard_stall_unit #(.REG_W(5), .STAT_W(32)) dut (.clk(clk), .reset(reset), .hs(hsif));
  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [2:0] pcsrc;
    logic       bt;
    logic [4:0] exrd;
    logic       exwr, exld;
    logic [4:0] mrd;
    logic       mld, mwr;
    logic [3:0] exp; // {PC_write, IFID_write, IFID_flush, IDEX_flush}
  } vec_t;
  vec_t tbl[13];
  function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt, logic [2:0] pcsrc,
                              logic bt, logic [4:0] exrd, logic exwr, logic exld,
                              logic [4:0] mrd, logic mld, logic mwr, logic [3:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.pcsrc = pcsrc; v.bt = bt;
    v.exrd = exrd; v.exwr = exwr; v.exld = exld; v.mrd = mrd; v.mld = mld; v.mwr = mwr; v.exp = exp;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    hsif.IFID_rs = v.rs; hsif.IFID_rt = v.rt; hsif.IFID_use_rs = v.urs; hsif.IFID_use_rt = v.urt;
    hsif.IFID_pcsrc = v.pcsrc; hsif.branch_taken = v.bt;
    hsif.IDEX_rd = v.exrd; hsif.IDEX_regwr = v.exwr; hsif.IDEX_memrd = v.exld;
    hsif.EXMEM_rd = v.mrd; hsif.EXMEM_memrd = v.mld; hsif.EXMEM_regwr = v.mwr;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [3:0] outs();
    return {hsif.PC_write, hsif.IFID_write, hsif.IFID_flush, hsif.IDEX_flush};
  endfunction
  localparam logic [3:0] IDLE = 4'b1100, STALL = 4'b0001, FLUSH = 4'b1110;
  initial begin
    logic [31:0] exp_st, exp_fl;
    //            rs  rt urs urt pcsrc   bt exrd wr ld  mrd ld wr exp
    tbl[0]  = mk(0,  0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, IDLE);
    tbl[1]  = mk(1,  2, 1, 1, 3'b000, 0, 2, 1, 1, 0, 0, 0, STALL);  // lw $2 -> add uses rt
    tbl[2]  = mk(1,  2, 1, 1, 3'b000, 0, 0, 0, 0, 2, 1, 1, IDLE);   // load now in MEM
    tbl[3]  = mk(3,  5, 1, 1, 3'b001, 0, 3, 1, 1, 0, 0, 0, STALL);  // lw $3 -> beq: N=2
    tbl[4]  = mk(3,  5, 1, 1, 3'b001, 0, 0, 0, 0, 3, 1, 1, STALL);  // HOLD
    tbl[5]  = mk(3,  5, 1, 1, 3'b001, 1, 0, 0, 0, 0, 0, 0, FLUSH);  // taken on cycle 3
    tbl[6]  = mk(4,  0, 1, 0, 3'b011, 0, 4, 1, 0, 0, 0, 0, STALL);  // add $4 -> jr $4
    tbl[7]  = mk(4,  0, 1, 0, 3'b011, 0, 0, 0, 0, 4, 0, 1, FLUSH);  // forwarded, jr redirects
    tbl[8]  = mk(0,  0, 1, 1, 3'b000, 0, 0, 1, 1, 0, 0, 0, IDLE);   // lw $0 never stalls
    tbl[9]  = mk(5,  0, 1, 0, 3'b001, 1, 5, 1, 0, 0, 0, 0, STALL);  // stall beats taken branch
    tbl[10] = mk(0,  0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, FLUSH);  // plain jump
    tbl[11] = mk(6,  7, 1, 1, 3'b001, 1, 0, 0, 0, 7, 1, 1, STALL);  // branch on load in MEM
    tbl[12] = mk(1,  9, 1, 0, 3'b000, 0, 9, 1, 1, 0, 0, 0, IDLE);   // rt not read -> no dep
    apply(tbl[0]);
    #2 chk("reset_outs", 32'(outs()), 32'(IDLE));
    chk("reset_stall_cycles", hsif.stall_cycles, 0);
    chk("reset_flush_count", hsif.flush_count, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      @(posedge clk) #1;
      if (i == 8) begin
`ifdef HAZARD_STATS_EN
        exp_st = 4; exp_fl = 2;
`else
        exp_st = 0; exp_fl = 0;
`endif
        chk("stat_stall_cycles", hsif.stall_cycles, exp_st);
        chk("stat_flush_count", hsif.flush_count, exp_fl);
      end
    end
    // async reset while in HOLD
    apply(tbl[3]);
    @(posedge clk) #1;
    apply(tbl[0]);
    #1 chk("hold_before_reset", 32'(outs()), 32'(STALL));
    #1 reset = 1'b0;
    #1 chk("reset_in_hold_outs", 32'(outs()), 32'(IDLE));
    chk("reset_in_hold_stats", hsif.stall_cycles | hsif.flush_count, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk) #1;
    @(negedge clk) chk("after_reset_idle", 32'(outs()), 32'(IDLE));
    apply(tbl[1]);
    #1 chk("after_reset_detect", 32'(outs()), 32'(STALL));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
